// File: rtl/level_event_detector.sv
// Magnitude level event detector: asserts after ASSERT_N consecutive samples at or above thr_hi,
// releases after HOLD consecutive samples below thr_lo, with peak and saturating event counters.
module level_event_detector #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter int ASSERT_N = 2,
  parameter int HOLD     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] probe,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  input  logic             clr,
  output logic             detected,
  output logic             rise,
  output logic [WIDTH-1:0] peak,
  output logic [CNT_W-1:0] event_cnt
);
  localparam int AW = $clog2(ASSERT_N + 1);
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {IDLE, ARMING, DETECTED, HOLDING} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    acnt, acnt_nx;
  logic [HW-1:0]    hcnt, hcnt_nx;
  logic [WIDTH-1:0] mag;
  logic             hi, lo, fire;

  // two's-complement negate of the most negative value yields 2^(WIDTH-1), read as unsigned
  assign mag = probe[WIDTH-1] ? (~probe + WIDTH'(1)) : probe;
  assign hi  = (mag >= thr_hi);
  assign lo  = (mag <  thr_lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      acnt  <= acnt_nx;
      hcnt  <= hcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acnt_nx  = acnt;
    hcnt_nx  = hcnt;
    if (en) begin
      case (state)
        IDLE: if (hi) begin
          if (ASSERT_N == 1) state_nx = DETECTED;
          else begin
            state_nx = ARMING;
            acnt_nx  = AW'(1);
          end
        end
        ARMING: if (hi) begin
          if (acnt + AW'(1) == AW'(ASSERT_N)) begin
            state_nx = DETECTED;
            acnt_nx  = '0;
          end else acnt_nx = acnt + AW'(1);
        end else begin
          state_nx = IDLE;
          acnt_nx  = '0;
        end
        DETECTED: if (lo) begin
          if (HOLD == 1) state_nx = IDLE;
          else begin
            state_nx = HOLDING;
            hcnt_nx  = HW'(1);
          end
        end
        HOLDING: if (!lo) begin
          state_nx = DETECTED;
          hcnt_nx  = '0;
        end else if (hcnt + HW'(1) == HW'(HOLD)) begin
          state_nx = IDLE;
          hcnt_nx  = '0;
        end else hcnt_nx = hcnt + HW'(1);
        default: begin
          state_nx = IDLE;
          acnt_nx  = '0;
          hcnt_nx  = '0;
        end
      endcase
    end
  end

  // only entries from the not-detected side count as a new event
  always_comb begin
    detected = (state == DETECTED) || (state == HOLDING);
    fire     = !detected && (state_nx == DETECTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise      <= 1'b0;
      peak      <= '0;
      event_cnt <= '0;
    end else begin
      rise <= fire;
      if (clr) begin
        peak      <= '0;
        event_cnt <= '0;
      end else begin
        if (en && mag > peak) peak <= mag;
        if (fire && event_cnt != '1) event_cnt <= event_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_level_event_detector.sv
// Bench for level_event_detector: directed test-plan scenarios plus random stimulus
// checked against a run-length reference model; a CNT_W=2 copy covers saturation.
module tb_level_event_detector;
  localparam int W = 16;
  localparam int ASSERT_N = 2;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  probe = '0;
  logic [W-1:0]  thr_hi = 16'h4000;
  logic [W-1:0]  thr_lo = 16'h2000;
  logic          clr = 1'b0;
  logic          detected, rise, detected2, rise2;
  logic [W-1:0]  peak, peak2;
  logic [7:0]    event_cnt;
  logic [1:0]    event_cnt2;

  int checks = 0;
  int passed = 0;

  // reference model state
  int m_det, m_rise, m_peak, m_cnt, m_cnt2, run_hi, run_lo;

  always #5 clk = ~clk;

  level_event_detector #(.WIDTH(W), .CNT_W(8), .ASSERT_N(ASSERT_N), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .probe(probe), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .clr(clr), .detected(detected), .rise(rise), .peak(peak), .event_cnt(event_cnt));

  level_event_detector #(.WIDTH(W), .CNT_W(2), .ASSERT_N(ASSERT_N), .HOLD(HOLD)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .probe(probe), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .clr(clr), .detected(detected2), .rise(rise2), .peak(peak2), .event_cnt(event_cnt2));

  task automatic model_reset();
    m_det = 0; m_rise = 0; m_peak = 0; m_cnt = 0; m_cnt2 = 0; run_hi = 0; run_lo = 0;
  endtask

  task automatic model_step();
    int s, mg;
    s  = $signed(probe);
    mg = (s < 0) ? -s : s;
    m_rise = 0;
    if (en) begin
      if (mg > m_peak) m_peak = mg;
      if (m_det == 0) begin
        run_hi = (mg >= int'(thr_hi)) ? run_hi + 1 : 0;
        if (run_hi >= ASSERT_N) begin
          m_det = 1; m_rise = 1; run_hi = 0; run_lo = 0;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end else begin
        run_lo = (mg < int'(thr_lo)) ? run_lo + 1 : 0;
        if (run_lo >= HOLD) begin
          m_det = 0; run_lo = 0;
        end
      end
    end
    if (clr) begin
      m_peak = 0; m_cnt = 0; m_cnt2 = 0;
    end
  endtask

  task automatic step(input bit e, input logic [W-1:0] p);
    en = e; probe = p;
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    checks++;
    if (detected !== 1'b0 || rise !== 1'b0 || peak !== '0 || event_cnt !== '0)
      $display("FAIL reset: det=%b rise=%b peak=%h cnt=%0d, want all 0", detected, rise, peak, event_cnt);
    else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_sample();
    do_reset();
    step(1'b1, 16'h7FFF);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0000);
    checks++;
    if (detected !== 1'b0 || event_cnt !== 8'd0 || peak !== 16'h7FFF)
      $display("FAIL single_sample: det=%b cnt=%0d peak=%h, want 0/0/7fff", detected, event_cnt, peak);
    else passed++;
  endtask

  task automatic test_assert_hyst();
    do_reset();
    step(1'b1, 16'h5000);
    checks++;
    if (detected !== 1'b0) $display("FAIL assert_early: det=%b want 0", detected); else passed++;
    step(1'b1, 16'hB000);
    checks++;
    if (detected !== 1'b1 || rise !== 1'b1 || event_cnt !== 8'd1 || peak !== 16'h5000)
      $display("FAIL assert: det=%b rise=%b cnt=%0d peak=%h, want 1/1/1/5000", detected, rise, event_cnt, peak);
    else passed++;
    step(1'b1, 16'h3000);
    checks++;
    if (rise !== 1'b0) $display("FAIL rise_pulse: rise=%b want 0", rise); else passed++;
    for (int i = 0; i < 9; i++) step(1'b1, 16'h3000);
    checks++;
    if (detected !== 1'b1) $display("FAIL hyst_band: det=%b want 1", detected); else passed++;
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1000);
    step(1'b1, 16'h3000);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1000);
    checks++;
    if (detected !== 1'b1 || rise !== 1'b0) $display("FAIL hold_early: det=%b rise=%b want 1/0", detected, rise);
    else passed++;
    step(1'b1, 16'h1000);
    checks++;
    if (detected !== 1'b0 || rise !== 1'b0 || event_cnt !== 8'd1)
      $display("FAIL release: det=%b rise=%b cnt=%0d want 0/0/1", detected, rise, event_cnt);
    else passed++;
  endtask

  task automatic test_most_negative();
    do_reset();
    step(1'b1, 16'h8000);
    step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
    checks++;
    if (detected !== 1'b0 || peak !== 16'h8000) $display("FAIL en_gap: det=%b peak=%h want 0/8000", detected, peak);
    else passed++;
    step(1'b1, 16'h8000);
    checks++;
    if (detected !== 1'b1 || rise !== 1'b1 || peak !== 16'h8000)
      $display("FAIL most_negative: det=%b rise=%b peak=%h want 1/1/8000", detected, rise, peak);
    else passed++;
  endtask

  task automatic test_saturate_clr();
    int exp2;
    do_reset();
    for (int ev = 1; ev <= 5; ev++) begin
      step(1'b1, 16'h5000);
      step(1'b1, 16'h5000);
      for (int i = 0; i < HOLD; i++) step(1'b1, 16'h0000);
      exp2 = (ev > 3) ? 3 : ev;
      checks++;
      if (event_cnt2 !== 2'(exp2) || event_cnt !== 8'(ev))
        $display("FAIL saturate ev%0d: cnt2=%0d cnt=%0d want %0d/%0d", ev, event_cnt2, event_cnt, exp2, ev);
      else passed++;
    end
    clr = 1'b1;
    step(1'b0, 16'h0000);
    clr = 1'b0;
    checks++;
    if (event_cnt2 !== 2'd0 || event_cnt !== 8'd0 || peak !== '0 || peak2 !== '0)
      $display("FAIL clr: cnt2=%0d cnt=%0d peak=%h want 0/0/0", event_cnt2, event_cnt, peak);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 16'h5000);
    step(1'b1, 16'h5000);
    step(1'b1, 16'h1000);
    step(1'b1, 16'h1000);
    rst_n = 1'b0; #1;
    checks++;
    if (detected !== 1'b0 || peak !== '0 || event_cnt !== '0)
      $display("FAIL async_reset: det=%b peak=%h cnt=%0d want 0/0/0", detected, peak, event_cnt);
    else passed++;
    #1; rst_n = 1'b1;
    model_reset();
    step(1'b1, 16'h5000);
    step(1'b1, 16'h0000);
    checks++;
    if (detected !== 1'b0 || event_cnt !== '0)
      $display("FAIL rearm_after_reset: det=%b cnt=%0d want 0/0", detected, event_cnt);
    else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] p;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        thr_hi = W'($urandom_range(16'h1000, 16'h7000));
        thr_lo = ($urandom_range(0, 4) == 0) ? thr_hi + W'(16'h0800) : thr_hi - W'($urandom_range(0, 16'h0C00));
      end
      case ($urandom_range(0, 3))
        0: p = W'($urandom);
        1: p = thr_hi + W'($urandom_range(0, 4)) - W'(2);
        2: p = thr_lo + W'($urandom_range(0, 4)) - W'(2);
        default: p = ($urandom_range(0, 1) != 0) ? 16'h8000 : W'($urandom_range(0, 16'h0400));
      endcase
      if ($urandom_range(0, 1) != 0) p = ~p + W'(1);
      clr = ($urandom_range(0, 49) == 0);
      step($urandom_range(0, 3) != 0, p);
      checks++;
      if (detected !== m_det[0] || rise !== m_rise[0] || peak !== W'(m_peak) ||
          event_cnt !== 8'(m_cnt) || event_cnt2 !== 2'(m_cnt2))
        $display("FAIL random n=%0d: det=%b rise=%b peak=%h cnt=%0d cnt2=%0d want %0d/%0d/%h/%0d/%0d",
                 n, detected, rise, peak, event_cnt, event_cnt2, m_det, m_rise, m_peak, m_cnt, m_cnt2);
      else passed++;
    end
    clr = 1'b0;
    thr_hi = 16'h4000;
    thr_lo = 16'h2000;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_sample();
    test_assert_hyst();
    test_most_negative();
    test_saturate_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
